// File: rtl/stat_pkg.sv
// Shared types and helpers for the statistics sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package stat_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EXEC = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Encoding equals the bit position in stat_mask / stat_valid.
   typedef enum logic [1:0] {
      STAT_VAR  = 2'd0,
      STAT_MEAN = 2'd1,
      STAT_MIN  = 2'd2,
      STAT_MAX  = 2'd3
   } stat_e;

   localparam logic [3:0] OP_MAX  = 4'b1000;
   localparam logic [3:0] OP_MIN  = 4'b0100;
   localparam logic [3:0] OP_MEAN = 4'b0010;
   localparam logic [3:0] OP_VAR  = 4'b0001;
   localparam logic [3:0] OP_IDLE = 4'b0000;

   typedef struct packed {
      logic  none;   // no set mask bit below cur
      stat_e stat;   // next stat when none is clear
   } next_stat_t;

   // Next requested stat strictly after cur in the order max > min > mean > var.
   function automatic next_stat_t next_stat(input logic [3:0] mask, input stat_e cur);
      next_stat_t r;
      r.none = 1'b1;
      r.stat = cur;
      case (cur)
         STAT_MAX: begin
            if (mask[2])      begin r.none = 1'b0; r.stat = STAT_MIN;  end
            else if (mask[1]) begin r.none = 1'b0; r.stat = STAT_MEAN; end
            else if (mask[0]) begin r.none = 1'b0; r.stat = STAT_VAR;  end
         end
         STAT_MIN: begin
            if (mask[1])      begin r.none = 1'b0; r.stat = STAT_MEAN; end
            else if (mask[0]) begin r.none = 1'b0; r.stat = STAT_VAR;  end
         end
         STAT_MEAN: begin
            if (mask[0])      begin r.none = 1'b0; r.stat = STAT_VAR;  end
         end
         default: r.none = 1'b1;
      endcase
      return r;
   endfunction

   // Highest-priority set bit; the caller guarantees mask is non-zero.
   function automatic stat_e first_stat(input logic [3:0] mask);
      next_stat_t r;
      r = next_stat(mask, STAT_MAX);
      return mask[3] ? STAT_MAX : r.stat;
   endfunction

   function automatic logic [3:0] stat_to_op(input stat_e s);
      logic [3:0] op;
      case (s)
         STAT_MAX:  op = OP_MAX;
         STAT_MIN:  op = OP_MIN;
         STAT_MEAN: op = OP_MEAN;
         default:   op = OP_VAR;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/stat_sequencer_if.sv
// Host/datapath bundle for the statistics sequencer; slave = sequencer side.
// Ports: job control (start, stat_mask), operand handshake (num_in/num_valid/num_ready),
//        datapath bus (numbers_o, op_o, result_i), results and status.
interface stat_sequencer_if;

   logic             start;
   logic [3:0]       stat_mask;
   logic [3:0]       num_in;
   logic             num_valid;
   logic             num_ready;
   logic [1:4][3:0]  numbers_o;
   logic [3:0]       op_o;
   logic [7:0]       result_i;
   logic [7:0]       max_q;
   logic [7:0]       min_q;
   logic [7:0]       mean_q;
   logic [7:0]       var_q;
   logic [3:0]       stat_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, stat_mask, num_in, num_valid, result_i,
      input  num_ready, numbers_o, op_o, max_q, min_q, mean_q, var_q,
             stat_valid, busy, done
   );

   modport slave (
      input  start, stat_mask, num_in, num_valid, result_i,
      output num_ready, numbers_o, op_o, max_q, min_q, mean_q, var_q,
             stat_valid, busy, done
   );

endinterface

// File: rtl/stat_sequencer_loader.sv
// Operand loader: accepts four serial operands into registers [1:4].
// Latency: operand visible on numbers_o the cycle after its accept; loaded_o pulses on the 4th accept.
// Backpressure: num_ready_o follows load_en_i; num_valid_i low simply stalls, no timeout.
// Ports: clk/rst, load_en_i (FSM in LOAD), clr_i (job start), num_in_i/num_valid_i,
//        num_ready_o, numbers_o, loaded_o.
module stat_operand_loader (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en_i,
   input  logic             clr_i,
   input  logic [3:0]       num_in_i,
   input  logic             num_valid_i,
   output logic             num_ready_o,
   output logic [1:4][3:0]  numbers_o,
   output logic             loaded_o
);

   logic [1:0]       idx_q, idx_d;
   logic [1:4][3:0]  numbers_q, numbers_d;
   logic             accept;

   assign accept      = load_en_i & num_valid_i;
   assign num_ready_o = load_en_i;
   assign loaded_o    = accept && (idx_q == 2'd3);
   assign numbers_o   = numbers_q;

   always_comb begin
      idx_d     = idx_q;
      numbers_d = numbers_q;
      if (clr_i) begin
         idx_d = 2'd0;
      end else if (accept) begin
         case (idx_q)
            2'd0:    numbers_d[1] = num_in_i;
            2'd1:    numbers_d[2] = num_in_i;
            2'd2:    numbers_d[3] = num_in_i;
            default: numbers_d[4] = num_in_i;
         endcase
         // Wraps to 0 after the 4th operand, ready for the next job.
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= 2'd0;
         numbers_q <= '0;
      end else begin
         idx_q     <= idx_d;
         numbers_q <= numbers_d;
      end
   end

endmodule

// File: rtl/stat_sequencer.sv
// Sequences the max/min/mean/var datapath: load 4 operands, step one-hot OP, capture results.
// Latency: 4 accepts + popcount(mask)*CALC_LAT EXEC cycles + 1 DONE cycle.
// Backpressure: stalls in LOAD while num_valid is low; start only honoured in IDLE.
// Ports: clk, rst (sync, active high), sif (slave side of stat_sequencer_if).
module stat_sequencer
   import stat_pkg::*;
#(
   parameter int CALC_LAT = 1   // cycles OP is held before result_i is sampled, 1..7
) (
   input  logic             clk,
   input  logic             rst,
   stat_sequencer_if.slave  sif
);

   localparam logic [2:0] CNT_LAST = 3'(CALC_LAT - 1);

   state_e      state_q, state_d;
   logic [3:0]  mask_q, mask_d;
   stat_e       cur_q, cur_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  max_q, max_d;
   logic [7:0]  min_q, min_d;
   logic [7:0]  mean_q, mean_d;
   logic [7:0]  var_q, var_d;
   logic [3:0]  stat_valid_q, stat_valid_d;

   logic        start_acc;
   logic        load_en;
   logic        loaded;
   logic        cap;
   next_stat_t  nxt;
   logic        busy;
   logic        done;
   logic [3:0]  op;

   stat_operand_loader u_loader (
      .clk         (clk),
      .rst         (rst),
      .load_en_i   (load_en),
      .clr_i       (start_acc),
      .num_in_i    (sif.num_in),
      .num_valid_i (sif.num_valid),
      .num_ready_o (sif.num_ready),
      .numbers_o   (sif.numbers_o),
      .loaded_o    (loaded)
   );

   assign start_acc = (state_q == ST_IDLE) & sif.start;
   assign cap       = (state_q == ST_EXEC) && (cnt_q == CNT_LAST);
   assign nxt       = next_stat(mask_q, cur_q);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (sif.start)         state_d = ST_LOAD;
         ST_LOAD: if (loaded)            state_d = ST_EXEC;
         ST_EXEC: if (cap && nxt.none)   state_d = ST_DONE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; op is driven straight from cur_q so it only moves at stat boundaries.
   always_comb begin
      busy    = 1'b1;
      done    = 1'b0;
      load_en = 1'b0;
      op      = OP_IDLE;
      case (state_q)
         ST_IDLE: busy    = 1'b0;
         ST_LOAD: load_en = 1'b1;
         ST_EXEC: op      = stat_to_op(cur_q);
         default: done    = 1'b1;
      endcase
   end

   // Job datapath: mask latch, stat pointer, wait counter, result capture.
   always_comb begin
      mask_d       = mask_q;
      cur_d        = cur_q;
      cnt_d        = cnt_q;
      max_d        = max_q;
      min_d        = min_q;
      mean_d       = mean_q;
      var_d        = var_q;
      stat_valid_d = stat_valid_q;

      if (start_acc) begin
         // An empty mask means "everything".
         mask_d       = (sif.stat_mask == 4'b0000) ? 4'b1111 : sif.stat_mask;
         stat_valid_d = 4'b0000;
      end

      if (loaded) begin
         cur_d = first_stat(mask_q);
         cnt_d = 3'd0;
      end

      if (state_q == ST_EXEC) begin
         if (cap) begin
            case (cur_q)
               STAT_MAX:  max_d  = sif.result_i;
               STAT_MIN:  min_d  = sif.result_i;
               STAT_MEAN: mean_d = sif.result_i;
               default:   var_d  = sif.result_i;
            endcase
            stat_valid_d[cur_q] = 1'b1;
            cnt_d = 3'd0;
            if (!nxt.none) cur_d = nxt.stat;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q       <= 4'b0000;
         cur_q        <= STAT_MAX;
         cnt_q        <= 3'd0;
         max_q        <= 8'h00;
         min_q        <= 8'h00;
         mean_q       <= 8'h00;
         var_q        <= 8'h00;
         stat_valid_q <= 4'b0000;
      end else begin
         mask_q       <= mask_d;
         cur_q        <= cur_d;
         cnt_q        <= cnt_d;
         max_q        <= max_d;
         min_q        <= min_d;
         mean_q       <= mean_d;
         var_q        <= var_d;
         stat_valid_q <= stat_valid_d;
      end
   end

   assign sif.op_o       = op;
   assign sif.busy       = busy;
   assign sif.done       = done;
   assign sif.max_q      = max_q;
   assign sif.min_q      = min_q;
   assign sif.mean_q     = mean_q;
   assign sif.var_q      = var_q;
   assign sif.stat_valid = stat_valid_q;

endmodule

// File: tb/tb_stat_sequencer.sv
// Directed bench for stat_sequencer: one instance at CALC_LAT=1, one at CALC_LAT=3.
// Drives at #1 after posedge, samples at the same point.
module tb_stat_sequencer;
   import stat_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stat_sequencer_if if1 ();
   stat_sequencer_if if3 ();

   stat_sequencer #(.CALC_LAT(1)) dut1 (.clk(clk), .rst(rst), .sif(if1));
   stat_sequencer #(.CALC_LAT(3)) dut3 (.clk(clk), .rst(rst), .sif(if3));

   int tests_run    = 0;
   int tests_failed = 0;

   logic       dp_real = 1'b0;
   logic [3:0] op_log [0:7];
   int         op_n;
   int         cyc;

   // Datapath model for dut1: max, min and mean of the operands (var not needed).
   function automatic logic [7:0] real_dp(input logic [3:0] op, input logic [1:4][3:0] n);
      logic [3:0] mx, mn;
      logic [5:0] sum;
      mx  = n[1];
      mn  = n[1];
      sum = 6'd0;
      for (int i = 1; i <= 4; i++) begin
         if (n[i] > mx) mx = n[i];
         if (n[i] < mn) mn = n[i];
         sum = sum + 6'(n[i]);
      end
      case (op)
         OP_MAX:  return {4'h0, mx};
         OP_MIN:  return {4'h0, mn};
         OP_MEAN: return {4'h0, sum[5:2]};
         default: return 8'h00;
      endcase
   endfunction

   always_comb if1.result_i = dp_real ? real_dp(if1.op_o, if1.numbers_o)
                                      : (8'hA0 | {4'h0, if1.op_o});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start1(input logic [3:0] m);
      if1.start     = 1'b1;
      if1.stat_mask = m;
      tick();
      if1.start     = 1'b0;
   endtask

   // Four back-to-back operands, first in the MSB nibble.
   task automatic feed1(input logic [15:0] ops);
      for (int i = 0; i < 4; i++) begin
         if1.num_valid = 1'b1;
         if1.num_in    = ops[15-4*i -: 4];
         tick();
      end
      if1.num_valid = 1'b0;
   endtask

   // Log op_o each cycle until done; cyc = edges from call to the done cycle.
   task automatic exec1();
      op_n = 0;
      cyc  = 0;
      while (!if1.done && cyc < 20) begin
         if (op_n < 8) op_log[op_n] = if1.op_o;
         op_n++;
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      tests_run++; if (dut1.state_q !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dut1.state_q, ST_IDLE); end
      tests_run++; if ({if1.busy, if1.done, if1.num_ready} !== 3'b000) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 000", {if1.busy, if1.done, if1.num_ready}); end
      tests_run++; if (if1.op_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_op: got %b expected 0000", if1.op_o); end
      tests_run++; if (if1.numbers_o !== 16'h0000) begin tests_failed++; $display("FAIL reset_numbers: got %h expected 0000", if1.numbers_o); end
      tests_run++; if ({if1.max_q, if1.min_q, if1.mean_q, if1.var_q} !== 32'h0) begin tests_failed++; $display("FAIL reset_results: got %h expected 0", {if1.max_q, if1.min_q, if1.mean_q, if1.var_q}); end
      tests_run++; if (if1.stat_valid !== 4'b0000) begin tests_failed++; $display("FAIL reset_stat_valid: got %b expected 0000", if1.stat_valid); end
   endtask

   task automatic test_full_job();
      logic [15:0] exp_ops;
      exp_ops = 16'h8421;
      dp_real = 1'b0;
      start1(4'b0000);
      feed1(16'h3917);
      exec1();
      // 4 EXEC cycles after the last accept, so done is 8 edges after the start accept.
      tests_run++; if (op_n !== 4 || cyc !== 4) begin tests_failed++; $display("FAIL full_exec_len: got ops=%0d edges=%0d expected 4/4", op_n, cyc); end
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (op_log[i] !== exp_ops[15-4*i -: 4]) begin tests_failed++; $display("FAIL full_op%0d: got %b expected %b", i, op_log[i], exp_ops[15-4*i -: 4]); end
      end
      tests_run++; if (if1.done !== 1'b1 || if1.op_o !== 4'b0000 || if1.busy !== 1'b1) begin tests_failed++; $display("FAIL full_done_cycle: got done=%b op=%b busy=%b expected 1/0000/1", if1.done, if1.op_o, if1.busy); end
      tests_run++; if (if1.numbers_o !== 16'h3917) begin tests_failed++; $display("FAIL full_numbers: got %h expected 3917", if1.numbers_o); end
      tests_run++; if ({if1.max_q, if1.min_q, if1.mean_q, if1.var_q} !== 32'hA8A4A2A1) begin tests_failed++; $display("FAIL full_results: got %h expected a8a4a2a1", {if1.max_q, if1.min_q, if1.mean_q, if1.var_q}); end
      tests_run++; if (if1.stat_valid !== 4'b1111) begin tests_failed++; $display("FAIL full_stat_valid: got %b expected 1111", if1.stat_valid); end
      tick();
      tests_run++; if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin tests_failed++; $display("FAIL full_after_done: got done=%b busy=%b expected 0/0", if1.done, if1.busy); end
   endtask

   task automatic test_real_datapath();
      logic bad;
      bad     = 1'b0;
      dp_real = 1'b1;
      start1(4'b1100);
      feed1(16'h3917);
      exec1();
      for (int i = 0; i < 8; i++)
         if (i < op_n && (op_log[i] == OP_MEAN || op_log[i] == OP_VAR)) bad = 1'b1;
      tests_run++; if (op_n !== 2 || bad !== 1'b0) begin tests_failed++; $display("FAIL real_ops: got count=%0d bad=%b expected 2/0", op_n, bad); end
      tests_run++; if ({if1.max_q, if1.min_q} !== 16'h0901) begin tests_failed++; $display("FAIL real_max_min: got %h expected 0901", {if1.max_q, if1.min_q}); end
      tests_run++; if ({if1.mean_q, if1.var_q} !== 16'hA2A1) begin tests_failed++; $display("FAIL real_kept: got %h expected a2a1", {if1.mean_q, if1.var_q}); end
      tests_run++; if (if1.stat_valid !== 4'b1100) begin tests_failed++; $display("FAIL real_stat_valid: got %b expected 1100", if1.stat_valid); end
      tick();
      dp_real = 1'b0;
   endtask

   task automatic test_handshake_stall();
      logic [6:0]  pat;
      logic [15:0] vals;
      int          k;
      pat  = 7'b1001101;
      vals = 16'h5628;
      k    = 0;
      start1(4'b1111);
      for (int i = 0; i < 7; i++) begin
         if1.num_valid = pat[6-i];
         if1.num_in    = pat[6-i] ? vals[15-4*k -: 4] : 4'hF;
         tests_run++; if (if1.num_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_ready%0d: got %b expected 1", i, if1.num_ready); end
         tick();
         if (pat[6-i]) k++;
      end
      if1.num_valid = 1'b0;
      tests_run++; if (if1.num_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready_drop: got %b expected 0", if1.num_ready); end
      tests_run++; if (if1.numbers_o !== 16'h5628) begin tests_failed++; $display("FAIL stall_numbers: got %h expected 5628", if1.numbers_o); end
      exec1();
      tests_run++; if (if1.done !== 1'b1) begin tests_failed++; $display("FAIL stall_done: got %b expected 1", if1.done); end
      tick();
   endtask

   task automatic test_calc_lat3();
      int n;
      if3.start     = 1'b1;
      if3.stat_mask = 4'b0001;
      tick();
      if3.start     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if3.num_valid = 1'b1;
         if3.num_in    = 4'(i + 1);
         tick();
      end
      if3.num_valid = 1'b0;
      if3.result_i  = 8'h11;
      n = 0;
      while (if3.op_o !== 4'b0000 && n < 10) begin
         n++;
         if (n == 3) begin
            tests_run++; if (if3.var_q !== 8'h00 || if3.stat_valid !== 4'b0000) begin tests_failed++; $display("FAIL lat3_early: got var=%h valid=%b expected 00/0000", if3.var_q, if3.stat_valid); end
            if3.result_i = 8'h22;
         end
         tests_run++; if (if3.op_o !== OP_VAR) begin tests_failed++; $display("FAIL lat3_op%0d: got %b expected 0001", n, if3.op_o); end
         tick();
      end
      tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL lat3_hold: got %0d expected 3", n); end
      tests_run++; if (if3.var_q !== 8'h22 || if3.stat_valid !== 4'b0001) begin tests_failed++; $display("FAIL lat3_capture: got var=%h valid=%b expected 22/0001", if3.var_q, if3.stat_valid); end
      tests_run++; if (if3.done !== 1'b1) begin tests_failed++; $display("FAIL lat3_done: got %b expected 1", if3.done); end
      tick();
   endtask

   task automatic test_reset_mid_exec();
      start1(4'b1111);
      feed1(16'h3917);
      tests_run++; if (if1.op_o !== OP_MAX) begin tests_failed++; $display("FAIL rst_pre_op: got %b expected 1000", if1.op_o); end
      tick();
      tests_run++; if (if1.max_q !== 8'hA8) begin tests_failed++; $display("FAIL rst_pre_max: got %h expected a8", if1.max_q); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run++; if (dut1.state_q !== ST_IDLE) begin tests_failed++; $display("FAIL rst_state: got %0d expected %0d", dut1.state_q, ST_IDLE); end
      tests_run++; if ({if1.busy, if1.done, if1.num_ready, if1.op_o} !== 7'b0) begin tests_failed++; $display("FAIL rst_ctrl: got %b expected 0", {if1.busy, if1.done, if1.num_ready, if1.op_o}); end
      tests_run++; if ({if1.numbers_o, if1.max_q, if1.min_q, if1.mean_q, if1.var_q, if1.stat_valid} !== 52'h0) begin tests_failed++; $display("FAIL rst_data: got %h expected 0", {if1.numbers_o, if1.max_q, if1.min_q, if1.mean_q, if1.var_q, if1.stat_valid}); end
      start1(4'b0010);
      feed1(16'h1234);
      exec1();
      tests_run++; if (if1.done !== 1'b1 || if1.mean_q !== 8'hA2 || if1.max_q !== 8'h00) begin tests_failed++; $display("FAIL rst_rerun: got done=%b mean=%h max=%h expected 1/a2/00", if1.done, if1.mean_q, if1.max_q); end
      tests_run++; if (if1.stat_valid !== 4'b0010 || if1.numbers_o !== 16'h1234) begin tests_failed++; $display("FAIL rst_rerun_state: got valid=%b nums=%h expected 0010/1234", if1.stat_valid, if1.numbers_o); end
      tick();
   endtask

   task automatic test_start_held();
      if1.start     = 1'b1;
      if1.stat_mask = 4'b0000;
      tick();
      feed1(16'hABCD);
      exec1();
      tests_run++; if (if1.done !== 1'b1 || cyc !== 4) begin tests_failed++; $display("FAIL held_job: got done=%b edges=%0d expected 1/4", if1.done, cyc); end
      tick();
      tests_run++; if (dut1.state_q !== ST_IDLE || if1.busy !== 1'b0) begin tests_failed++; $display("FAIL held_idle: got state=%0d busy=%b expected %0d/0", dut1.state_q, if1.busy, ST_IDLE); end
      tick();
      tests_run++; if (dut1.state_q !== ST_LOAD || if1.num_ready !== 1'b1) begin tests_failed++; $display("FAIL held_restart: got state=%0d ready=%b expected %0d/1", dut1.state_q, if1.num_ready, ST_LOAD); end
      if1.start = 1'b0;
      feed1(16'h1111);
      exec1();
      tests_run++; if (if1.done !== 1'b1) begin tests_failed++; $display("FAIL held_second_done: got %b expected 1", if1.done); end
      tick();
   endtask

   initial begin
      if1.start = 1'b0; if1.stat_mask = 4'b0000; if1.num_in = 4'h0; if1.num_valid = 1'b0;
      if3.start = 1'b0; if3.stat_mask = 4'b0000; if3.num_in = 4'h0; if3.num_valid = 1'b0;
      if3.result_i = 8'h00;
      rst = 1'b1;
      tick();
      tick();
      test_reset();
      rst = 1'b0;
      tick();
      test_full_job();
      test_real_datapath();
      test_handshake_stall();
      test_calc_lat3();
      test_reset_mid_exec();
      test_start_held();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
